// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - two-requester arbiter/sequencer for a shared 4-bit adder/subtractor
module addsub_arbiter #(
  parameter bit RR_EN    = 1'b1,
  parameter bit INIT_PTR = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic       op0,
  output logic       ack0,
  output logic       done0,
  input  logic       req1,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  input  logic       op1,
  output logic       ack1,
  output logic       done1,
  output logic [3:0] au_a,
  output logic [3:0] au_b,
  output logic       au_e,
  input  logic [3:0] au_s,
  input  logic       au_cout,
  output logic [3:0] result,
  output logic       cout,
  output logic       ovf,
  output logic       zero,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  state_t state, state_nxt;
  logic   owner;
  logic   ptr;
  logic   any_req;
  logic   grant1;

  // requester 1 wins when alone, or when both ask and the round-robin pointer favours it
  always_comb begin
    any_req = req0 | req1;
    grant1  = req1 & (~req0 | (RR_EN & ptr));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner  <= 1'b0;
      ptr    <= INIT_PTR;
      au_a   <= 4'd0;
      au_b   <= 4'd0;
      au_e   <= 1'b0;
      result <= 4'd0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      if (state == IDLE && any_req) begin
        owner <= grant1;
        au_a  <= grant1 ? a1 : a0;
        au_b  <= grant1 ? b1 : b0;
        au_e  <= grant1 ? op1 : op0;
        if (RR_EN) ptr <= ~grant1;
      end
      // effective B operand is b^e, so overflow is "same input signs, different result sign"
      if (state == EXEC) begin
        result <= au_s;
        cout   <= au_cout;
        ovf    <= (au_a[3] == (au_b[3] ^ au_e)) && (au_s[3] != au_a[3]);
        zero   <= (au_s == 4'd0);
      end
    end
  end

  always_comb begin
    ack0  = 1'b0;
    ack1  = 1'b0;
    done0 = 1'b0;
    done1 = 1'b0;
    busy  = 1'b0;
    case (state)
      EXEC: begin
        ack0 = ~owner;
        ack1 = owner;
        busy = 1'b1;
      end
      DONE: begin
        done0 = ~owner;
        done1 = owner;
        busy  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb/tb_addsub_arbiter.sv - self-checking bench: round-robin and fixed-priority instances vs a behavioural model
module tb_addsub_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
  logic [3:0] a0 = 4'd0, b0 = 4'd0, a1 = 4'd0, b1 = 4'd0;

  logic       d_ack0[2], d_ack1[2], d_done0[2], d_done1[2], d_busy[2];
  logic [3:0] d_aua[2], d_aub[2], d_aus[2], d_res[2];
  logic       d_aue[2], d_auc[2], d_cout[2], d_ovf[2], d_zero[2];

  int  errors = 0;
  int  checks = 0;
  bit  chk_en = 1'b0;

  always #5 clk = ~clk;

  // index 0: round-robin instance, index 1: fixed-priority instance
  addsub_arbiter #(.RR_EN(1'b1), .INIT_PTR(1'b0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0), .op0(op0), .ack0(d_ack0[0]), .done0(d_done0[0]),
    .req1(req1), .a1(a1), .b1(b1), .op1(op1), .ack1(d_ack1[0]), .done1(d_done1[0]),
    .au_a(d_aua[0]), .au_b(d_aub[0]), .au_e(d_aue[0]), .au_s(d_aus[0]), .au_cout(d_auc[0]),
    .result(d_res[0]), .cout(d_cout[0]), .ovf(d_ovf[0]), .zero(d_zero[0]), .busy(d_busy[0])
  );

  addsub_arbiter #(.RR_EN(1'b0), .INIT_PTR(1'b0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0), .op0(op0), .ack0(d_ack0[1]), .done0(d_done0[1]),
    .req1(req1), .a1(a1), .b1(b1), .op1(op1), .ack1(d_ack1[1]), .done1(d_done1[1]),
    .au_a(d_aua[1]), .au_b(d_aub[1]), .au_e(d_aue[1]), .au_s(d_aus[1]), .au_cout(d_auc[1]),
    .result(d_res[1]), .cout(d_cout[1]), .ovf(d_ovf[1]), .zero(d_zero[1]), .busy(d_busy[1])
  );

  // external adder/subtractor: A + (B xor E) + E
  always_comb begin
    for (int k = 0; k < 2; k++)
      {d_auc[k], d_aus[k]} = {1'b0, d_aua[k]} + {1'b0, d_aub[k] ^ {4{d_aue[k]}}} + {4'd0, d_aue[k]};
  end

  typedef struct packed {
    logic [3:0] r;
    logic       c;
    logic       v;
    logic       z;
  } res_t;

  function automatic res_t calc(input logic [3:0] a, input logic [3:0] b, input logic op);
    int   sa, sb, s, u;
    res_t x;
    sa  = a[3] ? int'(a) - 16 : int'(a);
    sb  = b[3] ? int'(b) - 16 : int'(b);
    s   = op ? sa - sb : sa + sb;
    u   = op ? int'(a) - int'(b) : int'(a) + int'(b);
    x.r = u[3:0];
    x.c = op ? (a >= b) : (u > 15);
    x.v = (s > 7) || (s < -8);
    x.z = (u[3:0] == 4'd0);
    return x;
  endfunction

  // model: phase 0 waiting, 1 operands on the unit, 2 result returned
  int         m_ph[2]  = '{0, 0};
  logic       m_own[2] = '{1'b0, 1'b0};
  logic       m_ptr[2] = '{1'b0, 1'b0};
  logic [3:0] m_aa[2]  = '{4'd0, 4'd0};
  logic [3:0] m_ab[2]  = '{4'd0, 4'd0};
  logic       m_ae[2]  = '{1'b0, 1'b0};
  res_t       m_out[2] = '{'0, '0};
  res_t       m_pend[2] = '{'0, '0};
  logic       m_w[2];

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      m_w[k] = 1'b0;
      if (req1 && !req0)     m_w[k] = 1'b1;
      else if (req1 && req0) m_w[k] = (k == 0) ? m_ptr[k] : 1'b0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_ph[k]  <= 0;
        m_own[k] <= 1'b0;
        m_ptr[k] <= 1'b0;
        m_aa[k]  <= 4'd0;
        m_ab[k]  <= 4'd0;
        m_ae[k]  <= 1'b0;
        m_out[k] <= '0;
      end else if (m_ph[k] == 0) begin
        if (req0 || req1) begin
          m_ph[k]   <= 1;
          m_own[k]  <= m_w[k];
          m_aa[k]   <= m_w[k] ? a1 : a0;
          m_ab[k]   <= m_w[k] ? b1 : b0;
          m_ae[k]   <= m_w[k] ? op1 : op0;
          m_pend[k] <= m_w[k] ? calc(a1, b1, op1) : calc(a0, b0, op0);
          if (k == 0) m_ptr[k] <= ~m_w[k];
        end
      end else if (m_ph[k] == 1) begin
        m_ph[k]  <= 2;
        m_out[k] <= m_pend[k];
      end else begin
        m_ph[k] <= 0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("ack0[%0d]", k),  d_ack0[k],  int'(m_ph[k] == 1 && !m_own[k]));
        chk($sformatf("ack1[%0d]", k),  d_ack1[k],  int'(m_ph[k] == 1 && m_own[k]));
        chk($sformatf("done0[%0d]", k), d_done0[k], int'(m_ph[k] == 2 && !m_own[k]));
        chk($sformatf("done1[%0d]", k), d_done1[k], int'(m_ph[k] == 2 && m_own[k]));
        chk($sformatf("busy[%0d]", k),  d_busy[k],  int'(m_ph[k] != 0));
        chk($sformatf("au_a[%0d]", k),  d_aua[k],   m_aa[k]);
        chk($sformatf("au_b[%0d]", k),  d_aub[k],   m_ab[k]);
        chk($sformatf("au_e[%0d]", k),  d_aue[k],   m_ae[k]);
        chk($sformatf("result[%0d]", k), d_res[k],  m_out[k].r);
        chk($sformatf("cout[%0d]", k),  d_cout[k],  m_out[k].c);
        chk($sformatf("ovf[%0d]", k),   d_ovf[k],   m_out[k].v);
        chk($sformatf("zero[%0d]", k),  d_zero[k],  m_out[k].z);
        chk($sformatf("ack_excl[%0d]", k),  int'(d_ack0[k] & d_ack1[k]), 0);
        chk($sformatf("done_excl[%0d]", k), int'(d_done0[k] & d_done1[k]), 0);
      end
    end
  end

  task automatic run_op(input bit who, input logic [3:0] a, input logic [3:0] b, input logic o,
                        input logic [3:0] er, input logic ec, input logic ev, input logic ez);
    @(negedge clk);
    if (who) begin req1 = 1'b1; a1 = a; b1 = b; op1 = o; end
    else     begin req0 = 1'b1; a0 = a; b0 = b; op0 = o; end
    @(negedge clk);
    chk("lit_ack", who ? d_ack1[0] : d_ack0[0], 1);
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    chk("lit_done",  who ? d_done1[0] : d_done0[0], 1);
    chk("lit_other_done", who ? d_done0[0] : d_done1[0], 0);
    chk("lit_result", d_res[0], er);
    chk("lit_cout",  d_cout[0], ec);
    chk("lit_ovf",   d_ovf[0],  ev);
    chk("lit_zero",  d_zero[0], ez);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_result", d_res[k], 0);
      chk("rst_busy", d_busy[k], 0);
      chk("rst_au_a", d_aua[k], 0);
      chk("rst_flags", {d_cout[k], d_ovf[k], d_zero[k], d_ack0[k], d_done1[k]}, 0);
    end

    // contention: both held high; rr alternates 0,1,0,1, fixed priority always picks 0
    @(negedge clk);
    req0 = 1'b1; a0 = 4'd1; b0 = 4'd2; op0 = 1'b0;
    req1 = 1'b1; a1 = 4'd9; b1 = 4'd3; op1 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk("rr_ack0", d_ack0[0], int'(i % 6 == 1));
      chk("rr_ack1", d_ack1[0], int'(i % 6 == 4));
      chk("fp_ack0", d_ack0[1], int'(i % 3 == 1));
      chk("fp_ack1", d_ack1[1], 0);
      if (i % 6 == 2) chk("rr_res0", d_res[0], 3);
      if (i % 6 == 5) chk("rr_res1", d_res[0], 6);
    end
    req0 = 1'b0;
    @(negedge clk);
    chk("rr_ack1_after_drop", d_ack1[0], 1);
    chk("fp_ack1_after_drop", d_ack1[1], 1);
    req1 = 1'b0;
    @(negedge clk);
    chk("fp_done1", d_done1[1], 1);
    chk("fp_res1", d_res[1], 6);

    run_op(1'b0, 4'd3,  4'd4, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0);
    run_op(1'b1, 4'd8,  4'd1, 1'b1, 4'd7, 1'b1, 1'b1, 1'b0);
    run_op(1'b0, 4'd5,  4'd5, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1);
    run_op(1'b1, 4'd7,  4'd1, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0);
    run_op(1'b0, 4'd15, 4'd1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);

    // reset in the middle of EXEC: op aborted, everything cleared at once
    @(negedge clk);
    req0 = 1'b1; a0 = 4'd2; b0 = 4'd2; op0 = 1'b0;
    @(negedge clk);
    req0 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", d_busy[0], 0);
    chk("midrst_ack0", d_ack0[0], 0);
    chk("midrst_result", d_res[0], 0);
    chk("midrst_au_a", d_aua[0], 0);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_done0", d_done0[0], 0);
    rst_n = 1'b1;
    run_op(1'b0, 4'd2, 4'd6, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for one shared 4-bit adder/subtractor instance, which sits outside this block. The arbiter grants one request at a time, latches its operands, and drives the shared unit from registers for a full cycle. It captures sum/carry, derives signed overflow and zero flags, and returns the result to the granted requester with a one-cycle done pulse. It sits between the switch/control logic and the adder-subtractor and seven-segment display path.

Parameters:
RR_EN, 1, 1 = round-robin priority; 0 = fixed priority with requester 0 always winning.
INIT_PTR, 0, priority pointer value after reset (0 favours requester 0, 1 favours requester 1).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req0  input  1  requester 0 request; held high until ack0.
a0  input  4  requester 0 operand A.
b0  input  4  requester 0 operand B.
op0  input  1  requester 0 operation (0 = add, 1 = subtract).
ack0  output  1  one-cycle pulse: requester 0 operands accepted.
done0  output  1  one-cycle pulse: result belongs to requester 0.
req1, a1, b1, op1, ack1, done1  same widths and meanings for requester 1.
au_a  output  4  operand A to the shared adder/subtractor (registered).
au_b  output  4  operand B to the shared unit (registered).
au_e  output  1  mode to the shared unit (registered).
au_s  input  4  sum/difference from the shared unit (combinational).
au_cout  input  1  carry out from the shared unit.
result  output  4  captured S.
cout  output  1  captured carry; for subtract, 1 = no borrow (A >= B unsigned).
ovf  output  1  signed two's-complement overflow of the captured op.
zero  output  1  result == 0.
busy  output  1  high in EXEC and DONE.

Behaviour:
- Reset (rst_n low, asynchronous) sets state IDLE, ptr = INIT_PTR, and clears every output: ack*, done*, au_*, result, cout, ovf, zero, busy = 0.
- FSM states are IDLE, EXEC and DONE. Each state lasts exactly one cycle except IDLE, which waits for a request.
- IDLE with no req: stay in IDLE.
- IDLE with any req: pick a winner.
  - Only one req is high: that requester wins.
  - Both are high and RR_EN=1: the requester pointed to by ptr wins.
  - Both are high and RR_EN=0: requester 0 wins.
  - On the clock edge, register the winner's a/b/op into au_a/au_b/au_e, record the owner, pulse ack_owner for the next cycle, and go to EXEC.
  - With RR_EN=1, set ptr to the non-winner.
- ack timing: ack is asserted during EXEC, the cycle after acceptance. The requester may drop req or change operands in that cycle.
- EXEC: au_* are stable for the whole cycle. On the clock edge, capture result<=au_s and cout<=au_cout, and compute:
  - ovf <= (au_a[3] == (au_b[3]^au_e)) && (au_s[3] != au_a[3])
  - zero <= (au_s == 0)
  - Then go to DONE.
- DONE: done_owner is high for this cycle only. Go to IDLE on the next edge.
- Latency and throughput: request seen in IDLE at edge N gives ack in cycle N+1, result valid and done in cycle N+2. Maximum throughput is one op per 3 cycles.
- result/cout/ovf/zero hold their values until the next EXEC capture. They are not cleared on return to IDLE.
- au_* hold the last operands until the next acceptance.
- Requests arriving in EXEC or DONE are not accepted. They are evaluated in the next IDLE cycle.
- A req dropped before ack is treated as withdrawn, with no ack and no done.
- A requester that keeps req high after its done is re-arbitrated normally. With RR_EN=1 and both requesters continuously high, grants alternate 0,1,0,1 starting at INIT_PTR.
- Reset asserted mid-operation aborts the op: no done is produced and all state is cleared immediately.
- ack0 and ack1 are never high together; done0 and done1 are never high together.

Test Plan:
- Reset: rst_n=0 mid-EXEC, then release -> all outputs 0, state IDLE, no done pulse; next req0 is served normally.
- Single add: req0, a0=3, b0=4, op0=0 -> ack0 1 cycle later; done0 2 cycles later with result=7, cout=0, ovf=0, zero=0.
- Subtract with overflow: req1, a1=4'b1000, b1=1, op1=1 -> result=4'b0111, cout=1, ovf=1; done1 only, done0 stays low.
- Subtract to zero: a0=5, b0=5, op0=1 -> result=0, cout=1, zero=1, ovf=0.
- Contention, RR_EN=1, INIT_PTR=0, both reqs held high for 4 ops -> grant order 0,1,0,1; ops spaced exactly 3 cycles apart; ack and done pulses are never simultaneous.
- Contention, RR_EN=0 -> req0 wins every arbitration. req1 is served only after req0 drops, i.e. its req seen in the IDLE cycle following req0's DONE.
